// File: rtl/gnn_pkg.sv
// Shared sizes, state encoding and weight word indices for the GNN input loader.
// Optional feature macro: GNN_LOADER_WEIGHT_KEEP_EN (feature-only frames).
package gnn_pkg;

  localparam int DW        = 5;
  localparam int NFEAT     = 16;
  localparam int NWGT      = 24;
  localparam int FRAME_LEN = NFEAT + NWGT;
  localparam int CW        = 6;

  typedef enum logic [1:0] {
    LOAD,
    FIRE,
    WAIT
  } loader_state_t;

  // Frame word index of each named weight
  localparam int W04_IDX = NFEAT + 0;
  localparam int W14_IDX = NFEAT + 1;
  localparam int W24_IDX = NFEAT + 2;
  localparam int W34_IDX = NFEAT + 3;
  localparam int W05_IDX = NFEAT + 4;
  localparam int W15_IDX = NFEAT + 5;
  localparam int W25_IDX = NFEAT + 6;
  localparam int W35_IDX = NFEAT + 7;
  localparam int W06_IDX = NFEAT + 8;
  localparam int W16_IDX = NFEAT + 9;
  localparam int W26_IDX = NFEAT + 10;
  localparam int W36_IDX = NFEAT + 11;
  localparam int W07_IDX = NFEAT + 12;
  localparam int W17_IDX = NFEAT + 13;
  localparam int W27_IDX = NFEAT + 14;
  localparam int W37_IDX = NFEAT + 15;
  localparam int W48_IDX = NFEAT + 16;
  localparam int W58_IDX = NFEAT + 17;
  localparam int W68_IDX = NFEAT + 18;
  localparam int W78_IDX = NFEAT + 19;
  localparam int W49_IDX = NFEAT + 20;
  localparam int W59_IDX = NFEAT + 21;
  localparam int W69_IDX = NFEAT + 22;
  localparam int W79_IDX = NFEAT + 23;

endpackage

// File: rtl/gnn_done_tracker.sv
// Sticky OR of the per-node output-ready flags during WAIT,
// all-seen detect and WAIT-cycle timeout (TIMEOUT=0 disables).
module gnn_done_tracker
  import gnn_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] done_i,
  output logic       all_seen,
  output logic       timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [7:0]    done_seen;
  logic [TW-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      done_seen <= '0;
      wcnt      <= '0;
    end else if (en) begin
      done_seen <= done_seen | done_i;
      wcnt      <= wcnt + 1'b1;
    end
  end

  assign all_seen = en && ((done_seen | done_i) == 8'hFF);
  assign timeout  = en && (TIMEOUT != 0) && (wcnt == LAST);

endmodule

// File: rtl/gnn_input_loader.sv
// Frame loader: shadow-buffers one frame of words, publishes it with in_ready.
// Optional macro GNN_LOADER_WEIGHT_KEEP_EN enables feature-only frames.
module gnn_input_loader
  import gnn_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  input  logic                  feat_only,
  output logic [NFEAT*DW-1:0]   feat_o,
  output logic [NWGT*DW-1:0]    wgt_o,
  output logic                  in_ready,
  input  logic [7:0]            done_i,
  output logic                  busy,
  output logic                  err
);

  loader_state_t state_q, state_d;

  logic [CW-1:0] cnt;
  logic [DW-1:0] shadow [FRAME_LEN];
  logic          fo;
  logic          acc;
  logic          last;
  logic          all_seen;
  logic          tmo;

`ifdef GNN_LOADER_WEIGHT_KEEP_EN
  logic fo_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      fo_q <= 1'b0;
    else if (acc && cnt == '0)
      fo_q <= feat_only;
  end

  assign fo = (cnt == '0) ? feat_only : fo_q;
`else
  logic unused_feat_only;

  assign unused_feat_only = feat_only;
  assign fo = 1'b0;
`endif

  assign s_ready  = rst_n && (state_q == LOAD);
  assign acc      = s_valid && s_ready;
  assign last     = cnt == (fo ? CW'(NFEAT - 1) : CW'(FRAME_LEN - 1));
  assign in_ready = state_q == FIRE;
  assign busy     = state_q != LOAD;

  gnn_done_tracker #(
    .TIMEOUT (TIMEOUT)
  ) u_done (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == FIRE),
    .en       (state_q == WAIT),
    .done_i   (done_i),
    .all_seen (all_seen),
    .timeout  (tmo)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == LOAD: if (acc && last) state_d = FIRE;
      state_q == FIRE: state_d = WAIT;
      state_q == WAIT: if (all_seen || tmo) state_d = LOAD;
      default:         state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc)
      shadow[cnt] <= s_data;
  end

  // The last word bypasses the shadow so the publish happens on its own edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt     <= '0;
      feat_o  <= '0;
      wgt_o   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tmo && !all_seen)
        err <= 1'b1;
      if (acc) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          for (int i = 0; i < NFEAT; i++)
            feat_o[i*DW +: DW] <= (cnt == CW'(i)) ? s_data : shadow[i];
          if (!fo)
            for (int i = 0; i < NWGT; i++)
              wgt_o[i*DW +: DW] <= (cnt == CW'(NFEAT + i)) ? s_data
                                                            : shadow[NFEAT + i];
        end
      end
    end
  end

endmodule
